// File: rtl/router_pkt_fifo.sv
// Router packet FIFO: stores {header flag, byte} words and tags read words with sof/eop.
// Optional sticky error output is built when ROUTER_PKT_FIFO_ERR_EN is defined.
module router_pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             sof,
    output logic             eop,
    output logic             full,
    output logic             empty,
`ifdef ROUTER_PKT_FIFO_ERR_EN
    output logic             err,
`endif
    output logic [AW:0]      count
);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    state_t           state_q;
    logic [WIDTH-2:0] pkt_rem_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q, sof_q, eop_q;

    logic             flush, wr_acc, rd_acc, rd_hdr;
    logic [WIDTH:0]   rd_word;
    logic [WIDTH-2:0] hdr_rem;

    assign flush   = !resetn || soft_reset;
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem_q[rd_ptr_q];
    assign rd_hdr  = rd_word[WIDTH];
    // Header length field is data[WIDTH-1:2]; one extra word for the trailing parity.
    assign hdr_rem = (WIDTH-1)'(rd_word[WIDTH-1:2]) + (WIDTH-1)'(1);

    always_ff @(posedge clock) begin
        if (!flush && wr_acc)
            mem_q[wr_ptr_q] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            pkt_rem_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase

            valid_q <= rd_acc;
            data_q  <= rd_acc ? rd_word[WIDTH-1:0] : '0;
            sof_q   <= 1'b0;
            eop_q   <= 1'b0;
            if (rd_acc) begin
                if (rd_hdr) begin
                    sof_q     <= 1'b1;
                    pkt_rem_q <= hdr_rem;
                    state_q   <= PAYLOAD;
                end else if (state_q == PAYLOAD) begin
                    pkt_rem_q <= pkt_rem_q - (WIDTH-1)'(1);
                    if (pkt_rem_q == (WIDTH-1)'(1)) begin
                        eop_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

`ifdef ROUTER_PKT_FIFO_ERR_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (flush)
            err_q <= 1'b0;
        else if ((write_enb && full) || (read_enb && empty) ||
                 (rd_acc && rd_hdr && state_q == PAYLOAD))
            err_q <= 1'b1;
    end

    assign err = err_q;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign sof        = sof_q;
    assign eop        = eop_q;
    assign count      = count_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: directed scenarios plus random traffic
// against a queue-based packet model.
module tb_router_pkt_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [WIDTH-1:0] d;
        bit               s;
        bit               e;
    } exp_t;

    logic             clock = 1'b0;
    logic             resetn = 1'b0, soft_reset = 1'b0;
    logic             write_enb = 1'b0, lfd_state = 1'b0, read_enb = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid, sof, eop, full, empty;
    logic [AW:0]      count;
`ifdef ROUTER_PKT_FIFO_ERR_EN
    logic             err;
`endif

    router_pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
        .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
        .sof(sof), .eop(eop), .full(full), .empty(empty),
`ifdef ROUTER_PKT_FIFO_ERR_EN
        .err(err),
`endif
        .count(count)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [WIDTH:0] m_q[$];
    exp_t           exp_q[$];
    int             rem = 0;
    bit             exp_valid = 0;
    bit             exp_err = 0;
    bit             mon_en = 0;

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge(input bit rn, input bit sr, input bit we, input bit lfd,
                              input logic [WIDTH-1:0] d, input bit re);
        bit   wa, ra;
        exp_t x;
        logic [WIDTH:0] w;
        if (!rn || sr) begin
            m_q.delete();
            exp_q.delete();
            rem = 0;
            exp_valid = 0;
            exp_err = 0;
            return;
        end
        wa = we && (m_q.size() < DEPTH);
        ra = re && (m_q.size() > 0);
        if ((we && !wa) || (re && !ra))
            exp_err = 1;
        exp_valid = ra;
        if (ra) begin
            w = m_q.pop_front();
            x.d = w[WIDTH-1:0];
            x.s = 0;
            x.e = 0;
            if (w[WIDTH]) begin
                if (rem > 0) exp_err = 1;
                rem = int'(w[WIDTH-1:0]) / 4 + 1;
                x.s = 1;
            end else if (rem > 0) begin
                rem = rem - 1;
                x.e = (rem == 0);
            end
            exp_q.push_back(x);
        end
        if (wa)
            m_q.push_back({lfd, d});
    endtask

    task automatic drive(input bit rn, input bit sr, input bit we, input bit lfd,
                         input logic [WIDTH-1:0] d, input bit re);
        resetn = rn; soft_reset = sr; write_enb = we; lfd_state = lfd;
        data_in = d; read_enb = re;
        @(posedge clock);
        model_edge(rn, sr, we, lfd, d, re);
        #1;
        write_enb = 0; read_enb = 0; lfd_state = 0; soft_reset = 0;
    endtask

    task automatic wr(input bit lfd, input logic [WIDTH-1:0] d);
        drive(1, 0, 1, lfd, d, 0);
    endtask

    task automatic rd();
        drive(1, 0, 0, 0, '0, 1);
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, '0, 0);
    endtask

    // Monitor: compares flags every cycle and pops the scoreboard whenever a word is presented
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                chk("count", int'(count), m_q.size());
                chk("full", int'(full), int'(m_q.size() == DEPTH));
                chk("empty", int'(empty), int'(m_q.size() == 0));
                chk("data_valid", int'(data_valid), int'(exp_valid));
`ifdef ROUTER_PKT_FIFO_ERR_EN
                chk("err", int'(err), int'(exp_err));
`endif
                if (data_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("data_out", int'(data_out), int'(x.d));
                        chk("sof", int'(sof), int'(x.s));
                        chk("eop", int'(eop), int'(x.e));
                    end
                end else begin
                    chk("idle_data", int'(data_out), 0);
                    chk("idle_sof_eop", int'({sof, eop}), 0);
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] d;
        bit lfd;

        do_reset();
        mon_en = 1;
        do_reset();

        // Fill from reset, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) wr(0, WIDTH'($urandom));
        wr(0, 8'hA5);
        for (int i = 0; i < DEPTH; i++) rd();
        idle();

        // Header len 3 + 3 payload + parity, reads spaced by idle cycles
        do_reset();
        wr(1, 8'h0C);
        for (int i = 0; i < 4; i++) wr(0, WIDTH'($urandom));
        for (int i = 0; i < 5; i++) begin rd(); idle(); end

        // Zero-length header, then a truncated packet followed by a fresh one
        wr(1, 8'h01);
        wr(0, 8'h77);
        wr(1, 8'h10);
        wr(0, 8'h11);
        wr(1, 8'h04);
        wr(0, 8'h22);
        wr(0, 8'h33);
        for (int i = 0; i < 7; i++) rd();
        idle();

        // Steady simultaneous read/write at count=8 across pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) wr(0, WIDTH'($urandom));
        for (int i = 0; i < 20; i++) drive(1, 0, 1, 0, WIDTH'($urandom), 1);
        idle();

        // Flush mid-packet at count=5, then confirm tracker is back in IDLE
        do_reset();
        wr(1, 8'h18);
        for (int i = 0; i < 6; i++) wr(0, WIDTH'($urandom));
        rd(); rd();
        drive(1, 1, 1, 0, 8'h55, 1);
        wr(0, 8'h66);
        rd();
        idle();

        // Read when empty; err (if built) must stick until resetn
        do_reset();
        rd();
        idle(); idle();
        wr(0, 8'h42);
        rd();
        idle();
        do_reset();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            lfd = ($urandom_range(0, 5) == 0);
            d = lfd ? WIDTH'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3))
                    : WIDTH'($urandom);
            drive(!($urandom_range(0, 299) == 0), ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 99) < 55), lfd, d, ($urandom_range(0, 99) < 50));
        end
        for (int i = 0; i < DEPTH + 2; i++) rd();
        idle();

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/router_pkt_fifo.md
ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload byte width (>=4).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of 2, >=4).
REQ-003 SHALL have local parameter AW = clog2(DEPTH), derived and not overridable.
REQ-004 SHALL have port clock  input  1  rising-edge clock for all logic.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port soft_reset  input  1  synchronous flush, active-high.
REQ-007 SHALL have port write_enb  input  1  write request.
REQ-008 SHALL have port lfd_state  input  1  marks data_in as packet header.
REQ-009 SHALL have port data_in  input  WIDTH  write data.
REQ-010 SHALL have port read_enb  input  1  read request.
REQ-011 SHALL have port data_out  output  WIDTH  registered read data; 0 when data_valid=0.
REQ-012 SHALL have port data_valid  output  1  data_out holds a word this cycle.
REQ-013 SHALL have port sof  output  1  data_out word is a header.
REQ-014 SHALL have port eop  output  1  data_out word is the last word (parity) of a packet.
REQ-015 SHALL have ports full, empty  output  1 each  occupancy flags.
REQ-016 SHALL have port count  output  AW+1  stored word count, 0..DEPTH.

Function
REQ-017 SHALL store WIDTH+1-bit entries {lfd_state, data_in}.
REQ-018 SHALL accept a write iff write_enb=1 and full=0; a write when full SHALL be dropped with no state change.
REQ-019 SHALL accept a read iff read_enb=1 and empty=0; a read when empty SHALL be ignored.
REQ-020 SHALL, on simultaneous accepted read and write, keep count unchanged and advance both pointers; at full, only the read SHALL be accepted; at empty, only the write.
REQ-021 SHALL use AW-bit pointers wrapping DEPTH-1 -> 0.
REQ-022 SHALL derive full = (count==DEPTH), empty = (count==0), both registered-consistent with count in the same cycle.
REQ-023 SHALL present the read word on data_out with data_valid=1 exactly one cycle after the accepting edge; data_valid SHALL be 0 in cycles following no accepted read.
REQ-024 SHALL run a 2-state read tracker: IDLE, PAYLOAD, with WIDTH-1-bit counter pkt_rem.
REQ-025 SHALL, on reading a header word, set sof=1, load pkt_rem = data[WIDTH-1:2] + 1 (payload plus parity), and enter PAYLOAD.
REQ-026 SHALL, in PAYLOAD, decrement pkt_rem on each accepted non-header read; the read that takes pkt_rem 1 -> 0 SHALL set eop=1 and return to IDLE.
REQ-027 SHALL treat a header read in PAYLOAD as a new packet (reload, sof=1, no eop for the truncated packet).
REQ-028 SHALL pass a non-header read in IDLE with sof=0, eop=0 and remain in IDLE.
REQ-029 SHALL, for header length 0, load pkt_rem=1 so the next word carries eop.

Reset
REQ-030 SHALL, when resetn=0 or soft_reset=1 at a clock edge, clear pointers, count=0, empty=1, full=0, data_out=0, data_valid=0, sof=0, eop=0, pkt_rem=0, state=IDLE; memory contents need not be cleared.
REQ-031 SHALL give reset/flush priority over any simultaneous read or write; requests in that cycle are discarded.

Configuration
REQ-032 SHALL, when macro ROUTER_PKT_FIFO_ERR_EN is defined, add output err (1 bit), sticky, set by a dropped write (REQ-018), an ignored read (REQ-019), or a truncated packet (REQ-027), cleared only by reset/flush.
REQ-033 SHALL, without ROUTER_PKT_FIFO_ERR_EN, have no err port and no error logic; all other behaviour identical.

Verification
REQ-034 SHALL cover: 16 writes from reset (DEPTH=16) -> full=1, count=16; 17th write dropped; 16 reads return data in write order.
REQ-035 SHALL cover: header 0x0C (len 3) + 3 payload + parity, then reads -> sof on word 1, eop on word 5, data_valid 1 cycle after each read.
REQ-036 SHALL cover: simultaneous read+write at count=8 for 20 cycles -> count stays 8, pointers wrap, data order preserved.
REQ-037 SHALL cover: soft_reset asserted mid-packet with count=5 -> next cycle count=0, empty=1, data_valid=0, state IDLE.
REQ-038 SHALL cover: with ROUTER_PKT_FIFO_ERR_EN, read when empty -> err=1 and held until resetn=0; without it, same stimulus -> no state change.
